// File: rtl/bell_sched.sv
// Alarm-clock bell scheduler: alarm with snooze plus an hourly chime that strikes the hour.
// One FSM owns the bell; the alarm always outranks the chime.
module bell_sched #(
    parameter int unsigned ALARM_LEN  = 60,
    parameter int unsigned SNOOZE_LEN = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       chime_en,
    input  logic       stop,
    input  logic       snooze,
    output logic       bell,
    output logic       alarm_active,
    output logic       chime_active,
    output logic       snoozing,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ALARM     = 3'd1,
        S_SNOOZE    = 3'd2,
        S_CHIME_ON  = 3'd3,
        S_CHIME_OFF = 3'd4
    } state_t;

    localparam logic [31:0] ALARM_LEN_W  = 32'(ALARM_LEN);
    localparam logic [31:0] SNOOZE_LEN_W = 32'(SNOOZE_LEN);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic [31:0] w_cnt_inc;
    logic [3:0]  r_strikes;
    logic [3:0]  w_strikes_nxt;
    logic [4:0]  w_hour_mod;
    logic [3:0]  w_hour_strikes;
    logic        w_alarm_hit;
    logic        w_chime_hit;
    logic        r_bell;
    logic        r_alarm_active;
    logic        r_chime_active;
    logic        r_snoozing;

    // Out-of-range alarm settings are rejected explicitly so they can never match.
    assign w_alarm_hit = alarm_en & tick_1hz & (alarm_hour <= 5'd23) & (alarm_min <= 6'd59)
                       & (cur_hour == alarm_hour) & (cur_min == alarm_min) & (cur_sec == 6'd0);
    assign w_chime_hit = chime_en & tick_1hz & (cur_min == 6'd0) & (cur_sec == 6'd0);

    assign w_cnt_inc      = r_cnt + 32'd1;
    assign w_hour_mod     = cur_hour % 5'd12;
    assign w_hour_strikes = (w_hour_mod == 5'd0) ? 4'd12 : w_hour_mod[3:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_strikes_nxt = r_strikes;
        case (r_state)
            S_IDLE: begin
                if (w_alarm_hit) begin
                    w_state_nxt = S_ALARM;
                    w_cnt_nxt   = 32'd0;
                end else if (w_chime_hit) begin
                    w_state_nxt   = S_CHIME_ON;
                    w_cnt_nxt     = 32'd0;
                    w_strikes_nxt = w_hour_strikes;
                end
            end
            S_ALARM: begin
                if (stop || !alarm_en) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 32'd0;
                end else if (snooze) begin
                    w_state_nxt = S_SNOOZE;
                    w_cnt_nxt   = 32'd0;
                end else if (tick_1hz) begin
                    if (w_cnt_inc >= ALARM_LEN_W) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 32'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            S_SNOOZE: begin
                if (stop || !alarm_en) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 32'd0;
                end else if (tick_1hz) begin
                    if (w_cnt_inc >= SNOOZE_LEN_W) begin
                        w_state_nxt = S_ALARM;
                        w_cnt_nxt   = 32'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            S_CHIME_ON, S_CHIME_OFF: begin
                if (stop || !chime_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_alarm_hit) begin
                    w_state_nxt = S_ALARM;
                    w_cnt_nxt   = 32'd0;
                end else if (tick_1hz) begin
                    if (r_state == S_CHIME_ON) begin
                        // The strike is consumed as the bell falls silent.
                        w_state_nxt = S_CHIME_OFF;
                        if (r_strikes != 4'd0) w_strikes_nxt = r_strikes - 4'd1;
                    end else begin
                        w_state_nxt = (r_strikes != 4'd0) ? S_CHIME_ON : S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= 32'd0;
            r_strikes      <= 4'd0;
            r_bell         <= 1'b0;
            r_alarm_active <= 1'b0;
            r_chime_active <= 1'b0;
            r_snoozing     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_strikes      <= w_strikes_nxt;
            r_bell         <= (w_state_nxt == S_ALARM) || (w_state_nxt == S_CHIME_ON);
            r_alarm_active <= (w_state_nxt == S_ALARM) || (w_state_nxt == S_SNOOZE);
            r_chime_active <= (w_state_nxt == S_CHIME_ON) || (w_state_nxt == S_CHIME_OFF);
            r_snoozing     <= (w_state_nxt == S_SNOOZE);
        end
    end

    assign bell         = r_bell;
    assign alarm_active = r_alarm_active;
    assign chime_active = r_chime_active;
    assign snoozing     = r_snoozing;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_bell_sched.sv
// Directed bench for bell_sched: alarm, snooze, hourly chime, priorities and reset.
// Outputs are sampled 1ns after the rising edge; expectations are hand-derived.
module tb_bell_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       alarm_en;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       chime_en;
    logic       stop;
    logic       snooze;
    logic       bell;
    logic       alarm_active;
    logic       chime_active;
    logic       snoozing;
    logic [2:0] dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    bell_sched #(.ALARM_LEN(60), .SNOOZE_LEN(300)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .chime_en(chime_en), .stop(stop), .snooze(snooze),
        .bell(bell), .alarm_active(alarm_active), .chime_active(chime_active),
        .snoozing(snoozing), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // {bell, alarm_active, chime_active, snoozing}
    function automatic logic [3:0] outs();
        return {bell, alarm_active, chime_active, snoozing};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hour = h; cur_min = m; cur_sec = s; tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        step();
    endtask

    // Ticks at a time that can never hit alarm or chime.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick(5'd23, 6'd59, 6'd59);
    endtask

    task automatic pulse(input logic do_stop, input logic do_snooze);
        stop = do_stop; snooze = do_snooze;
        step();
        stop = 1'b0; snooze = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (outs() !== 4'b0000) begin
            n_fail++; $display("FAIL reset_outs: got %b want 0000", outs());
        end
        n_cmp++;
        if (dbg_state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        // Hit presented on the first edge with reset released.
        alarm_hour = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1;
        rst_n = 1'b1;
        tick(5'd7, 6'd30, 6'd0);
        n_cmp++;
        if (outs() !== 4'b1100) begin
            n_fail++; $display("FAIL reset_release_hit: got %b want 1100", outs());
        end
        pulse(1'b1, 1'b0);
    endtask

    task automatic test_alarm_basic();
        alarm_hour = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1; chime_en = 1'b0;
        tick(5'd7, 6'd30, 6'd0);
        n_cmp++;
        if (outs() !== 4'b1100) begin
            n_fail++; $display("FAIL alarm_start: got %b want 1100", outs());
        end
        tick_n(59);
        n_cmp++;
        if (outs() !== 4'b1100) begin
            n_fail++; $display("FAIL alarm_59_ticks: got %b want 1100", outs());
        end
        tick_n(1);
        n_cmp++;
        if (outs() !== 4'b0000 || dbg_state !== 3'd0) begin
            n_fail++; $display("FAIL alarm_timeout: got %b/%0d want 0000/0", outs(), dbg_state);
        end
    endtask

    task automatic test_snooze();
        tick(5'd7, 6'd30, 6'd0);
        tick_n(10);
        n_cmp++;
        if (outs() !== 4'b1100) begin
            n_fail++; $display("FAIL snooze_pre: got %b want 1100", outs());
        end
        pulse(1'b0, 1'b1);
        n_cmp++;
        if (outs() !== 4'b0101) begin
            n_fail++; $display("FAIL snooze_enter: got %b want 0101", outs());
        end
        tick_n(299);
        n_cmp++;
        if (outs() !== 4'b0101) begin
            n_fail++; $display("FAIL snooze_299: got %b want 0101", outs());
        end
        tick_n(1);
        n_cmp++;
        if (outs() !== 4'b1100) begin
            n_fail++; $display("FAIL snooze_rering: got %b want 1100", outs());
        end
        pulse(1'b1, 1'b0);
        n_cmp++;
        if (outs() !== 4'b0000) begin
            n_fail++; $display("FAIL snooze_stop: got %b want 0000", outs());
        end
    endtask

    task automatic test_chime();
        logic [3:0] exp;
        int strikes_seen;
        bit done;
        alarm_en = 1'b0; chime_en = 1'b1;
        tick(5'd15, 6'd0, 6'd0);
        n_cmp++;
        if (outs() !== 4'b1010) begin
            n_fail++; $display("FAIL chime15_start: got %b want 1010", outs());
        end
        for (int i = 1; i <= 6; i++) begin
            tick_n(1);
            exp = (i == 6) ? 4'b0000 : ((i % 2 == 1) ? 4'b0010 : 4'b1010);
            n_cmp++;
            if (outs() !== exp) begin
                n_fail++; $display("FAIL chime15_tick%0d: got %b want %b", i, outs(), exp);
            end
        end
        tick(5'd0, 6'd0, 6'd0);
        strikes_seen = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (bell) strikes_seen++;
            if (outs() == 4'b0000) done = 1'b1;
            else tick_n(1);
        end
        n_cmp++;
        if (!done) begin
            n_fail++; $display("FAIL chime0_timeout: got busy want idle within 40 ticks");
        end
        n_cmp++;
        if (strikes_seen != 12) begin
            n_fail++; $display("FAIL chime0_strikes: got %0d want 12", strikes_seen);
        end
    endtask

    task automatic test_alarm_vs_chime();
        alarm_hour = 5'd8; alarm_min = 6'd0; alarm_en = 1'b1; chime_en = 1'b1;
        tick(5'd8, 6'd0, 6'd0);
        n_cmp++;
        if (outs() !== 4'b1100) begin
            n_fail++; $display("FAIL alarm_beats_chime: got %b want 1100", outs());
        end
        pulse(1'b1, 1'b0);
        alarm_hour = 5'd9; alarm_en = 1'b0;
        tick(5'd9, 6'd0, 6'd0);
        tick_n(1);
        n_cmp++;
        if (outs() !== 4'b0010) begin
            n_fail++; $display("FAIL chime9_off: got %b want 0010", outs());
        end
        alarm_en = 1'b1;
        tick(5'd9, 6'd0, 6'd0);
        n_cmp++;
        if (outs() !== 4'b1100) begin
            n_fail++; $display("FAIL chime_preempt: got %b want 1100", outs());
        end
        pulse(1'b1, 1'b0);
    endtask

    task automatic test_priority();
        alarm_hour = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1; chime_en = 1'b1;
        tick(5'd7, 6'd30, 6'd0);
        tick(5'd9, 6'd0, 6'd0);
        n_cmp++;
        if (outs() !== 4'b1100) begin
            n_fail++; $display("FAIL chime_ignored_in_alarm: got %b want 1100", outs());
        end
        pulse(1'b1, 1'b1);
        n_cmp++;
        if (outs() !== 4'b0000) begin
            n_fail++; $display("FAIL stop_beats_snooze: got %b want 0000", outs());
        end
        pulse(1'b0, 1'b1);
        n_cmp++;
        if (outs() !== 4'b0000 || dbg_state !== 3'd0) begin
            n_fail++; $display("FAIL snooze_in_idle: got %b/%0d want 0000/0", outs(), dbg_state);
        end
        tick(5'd7, 6'd30, 6'd0);
        alarm_en = 1'b0;
        pulse(1'b0, 1'b1);
        n_cmp++;
        if (outs() !== 4'b0000) begin
            n_fail++; $display("FAIL en_drop_beats_snooze: got %b want 0000", outs());
        end
        alarm_en = 1'b1;
        tick(5'd15, 6'd0, 6'd0);
        pulse(1'b0, 1'b1);
        n_cmp++;
        if (outs() !== 4'b1010) begin
            n_fail++; $display("FAIL snooze_in_chime: got %b want 1010", outs());
        end
        pulse(1'b1, 1'b0);
        n_cmp++;
        if (outs() !== 4'b0000) begin
            n_fail++; $display("FAIL stop_chime: got %b want 0000", outs());
        end
        tick(5'd15, 6'd0, 6'd0);
        chime_en = 1'b0;
        step();
        n_cmp++;
        if (outs() !== 4'b0000) begin
            n_fail++; $display("FAIL chime_en_drop: got %b want 0000", outs());
        end
    endtask

    task automatic test_reset_mid_snooze();
        alarm_hour = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1; chime_en = 1'b0;
        tick(5'd7, 6'd30, 6'd0);
        pulse(1'b0, 1'b1);
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (outs() !== 4'b0000) begin
            n_fail++; $display("FAIL reset_mid_snooze: got %b want 0000", outs());
        end
        rst_n = 1'b1;
        tick_n(300);
        n_cmp++;
        if (outs() !== 4'b0000) begin
            n_fail++; $display("FAIL no_ring_after_reset: got %b want 0000", outs());
        end
    endtask

    task automatic test_no_match();
        chime_en = 1'b0; alarm_en = 1'b1;
        alarm_hour = 5'd25; alarm_min = 6'd30;
        tick(5'd25, 6'd30, 6'd0);
        n_cmp++;
        if (outs() !== 4'b0000) begin
            n_fail++; $display("FAIL hour25_no_match: got %b want 0000", outs());
        end
        alarm_hour = 5'd7; alarm_min = 6'd60;
        tick(5'd7, 6'd60, 6'd0);
        n_cmp++;
        if (outs() !== 4'b0000) begin
            n_fail++; $display("FAIL min60_no_match: got %b want 0000", outs());
        end
        alarm_min = 6'd30; alarm_en = 1'b0;
        tick(5'd7, 6'd30, 6'd0);
        n_cmp++;
        if (outs() !== 4'b0000) begin
            n_fail++; $display("FAIL alarm_disabled: got %b want 0000", outs());
        end
    endtask

    initial begin
        rst_n = 1'b0; tick_1hz = 1'b0;
        cur_hour = '0; cur_min = '0; cur_sec = '0;
        alarm_en = 1'b0; alarm_hour = '0; alarm_min = '0;
        chime_en = 1'b0; stop = 1'b0; snooze = 1'b0;
        step();
        step();
        test_reset();
        test_alarm_basic();
        test_snooze();
        test_chime();
        test_alarm_vs_chime();
        test_priority();
        test_reset_mid_snooze();
        test_no_match();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bell_sched.md
BELL_SCHED -- requirements
Module: bell_sched

Interface
REQ-001 Parameter ALARM_LEN, 60, number of tick_1hz pulses an alarm rings before self-stopping.
REQ-002 Parameter SNOOZE_LEN, 300, number of tick_1hz pulses spent silent in snooze before ringing again.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 tick_1hz  input  1  one-cycle pulse; the cur_* time inputs hold the new second value on this cycle.
REQ-006 cur_hour  input  5  current hour, binary 0-23.
REQ-007 cur_min  input  6  current minute, binary 0-59.
REQ-008 cur_sec  input  6  current second, binary 0-59.
REQ-009 alarm_en  input  1  alarm enable, level.
REQ-010 alarm_hour  input  5  alarm hour, binary; values >23 never match.
REQ-011 alarm_min  input  6  alarm minute, binary; values >59 never match.
REQ-012 chime_en  input  1  hourly chime enable, level.
REQ-013 stop  input  1  one-cycle dismiss pulse.
REQ-014 snooze  input  1  one-cycle snooze pulse.
REQ-015 bell  output  1  registered bell drive, 1 = ringing.
REQ-016 alarm_active  output  1  registered; 1 in ALARM or SNOOZE.
REQ-017 chime_active  output  1  registered; 1 in CHIME_ON or CHIME_OFF.
REQ-018 snoozing  output  1  registered; 1 in SNOOZE.

Function
REQ-019 The FSM SHALL have states IDLE, ALARM, SNOOZE, CHIME_ON, CHIME_OFF, plus a 32-bit tick counter cnt and a 4-bit strike counter strikes.
REQ-020 alarm_hit = alarm_en & tick_1hz & cur_hour==alarm_hour & cur_min==alarm_min & cur_sec==0.
REQ-021 chime_hit = chime_en & tick_1hz & cur_min==0 & cur_sec==0.
REQ-022 IDLE: alarm_hit -> ALARM, cnt=0; else chime_hit -> CHIME_ON, cnt=0, strikes = cur_hour mod 12, with 0 mapped to 12.
REQ-023 ALARM: cnt increments on each tick; reaching ALARM_LEN -> IDLE; snooze -> SNOOZE, cnt=0; stop or alarm_en=0 -> IDLE.
REQ-024 SNOOZE: cnt increments on each tick; reaching SNOOZE_LEN -> ALARM, cnt=0; stop or alarm_en=0 -> IDLE.
REQ-025 CHIME_ON: next tick -> CHIME_OFF; strikes decrements on entering CHIME_OFF.
REQ-026 CHIME_OFF: next tick -> CHIME_ON if strikes!=0, else IDLE.
REQ-027 In CHIME_ON or CHIME_OFF, alarm_hit SHALL preempt to ALARM, cnt=0; stop or chime_en=0 -> IDLE.
REQ-028 chime_hit SHALL be ignored in ALARM and SNOOZE; alarm_hit SHALL be ignored in ALARM and SNOOZE.
REQ-029 Priority within one cycle: reset > stop > enable drop > snooze > alarm_hit > tick-driven count/transition.
REQ-030 snooze SHALL be ignored in IDLE and in chime states; stop SHALL be ignored in IDLE.
REQ-031 bell SHALL be 1 exactly when the registered state is ALARM or CHIME_ON.
REQ-032 Latency: a hit or a control pulse on cycle N SHALL change state and outputs at the edge ending cycle N, so they are visible in cycle N+1.
REQ-033 cnt comparisons SHALL be at 32 bits; cnt SHALL never wrap while in a counting state.

Reset
REQ-034 While rst_n=0 at a rising edge: state=IDLE, cnt=0, strikes=0, and bell, alarm_active, chime_active, snoozing all 0, regardless of state, including mid-alarm or mid-chime.
REQ-035 The first edge with rst_n=1 SHALL evaluate hits normally; a hit coincident with reset deassertion is honoured.

Verification
REQ-036 alarm 07:30, alarm_en=1, tick at 07:30:00 -> bell=1 next cycle; after 60 further ticks -> bell=0, state IDLE.
REQ-037 Alarm ringing, snooze after 10 ticks -> bell=0, snoozing=1; after 300 ticks -> bell=1, alarm_active=1; stop -> all outputs 0 next cycle.
REQ-038 chime_en=1, tick at 15:00:00 -> 3 strikes, bell pattern 1,0,1,0,1,0 per tick period, then IDLE; at 00:00:00 -> 12 strikes.
REQ-039 Chime at 08:00:00 with alarm 08:00 -> ALARM wins, chime_active stays 0; alarm 09:00 hit during the 09:00 chime -> preempts to ALARM.
REQ-040 stop and snooze on the same cycle in ALARM -> IDLE; rst_n=0 mid-SNOOZE -> all outputs 0 next cycle, no ring after SNOOZE_LEN ticks.
REQ-041 alarm_hour=25 or alarm_en=0 at the matching time -> bell stays 0.
